tt_wb_ctrl: RTL and testbench
=============================

TT_WB_CTRL -- requirements
Module: tt_wb_ctrl

Interface
REQ-001 The block SHALL have parameter N_CTRL, default 4, number of 32-bit read/write control registers (legal range 1..16).
REQ-002 The block SHALL have parameter N_IRQ, default 3, number of interrupt sources and user_irq lines (legal range 1..32).
REQ-003 The block SHALL have parameter BASE_ADR, default 32'h3000_0000, which is the decode window base (bits [7:0] ignored).
REQ-004 The block SHALL have parameter ID_VALUE, default 32'h5454_0001, which is the read-only identification word.
REQ-005 The block SHALL have parameter CTRL_RST, default 32'h0000_0000, which is the reset value of every control register.
REQ-006 clk  input  1  single clock for all logic.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone classic strobe/cycle/write.
REQ-009 wbs_sel_i  input  4  byte enables; wbs_adr_i  input  32; wbs_dat_i  input  32.
REQ-010 wbs_ack_o  output  1  acknowledge; wbs_dat_o  output  32  read data.
REQ-011 irq_src  input  N_IRQ  event sources, synchronous to clk, rising-edge sensitive.
REQ-012 ctrl_o  output  32*N_CTRL  control register contents, CTRL[i] at bits [32*i+31:32*i].
REQ-013 user_irq  output  N_IRQ  masked interrupt requests.

Function
REQ-014 A request SHALL be a cycle with wbs_stb_i & wbs_cyc_i high, wbs_ack_o low, and wbs_adr_i[31:8] == BASE_ADR[31:8] (a hit).
REQ-015 wbs_ack_o SHALL rise on the clock edge after a hit and stay high for exactly one cycle; a held strobe yields one ack every second cycle.
REQ-016 Non-hit addresses SHALL never be acknowledged and SHALL cause no state change.
REQ-017 The register map SHALL use word offsets from bits [7:2]: 0x00 ID (RO), 0x04 IRQ_STATUS (W1C), 0x08 IRQ_MASK (RW), 0x0C IRQ_FORCE (WO, reads 0), 0x10+4*i CTRL[i] (RW) for i < N_CTRL.
REQ-018 Writes SHALL take effect on the same edge that raises wbs_ack_o, honouring wbs_sel_i per byte for CTRL and IRQ_MASK; W1C/FORCE bits not covered by an asserted byte lane SHALL be ignored.
REQ-019 Unmapped offsets inside the window SHALL acknowledge, read 0, and ignore writes; bits at or above N_IRQ in IRQ registers SHALL read 0.
REQ-020 wbs_dat_o SHALL be registered, carry read data only while wbs_ack_o is high, and be 0 at all other times (including write acks).
REQ-021 irq_src SHALL be registered each cycle (prev); IRQ_STATUS[k] SHALL set on the edge where irq_src[k] & ~prev[k].
REQ-022 Writing 1 to IRQ_FORCE[k] SHALL set IRQ_STATUS[k]; writing 1 to IRQ_STATUS[k] SHALL clear it.
REQ-023 If a set (edge or force) and a W1C clear hit the same bit on the same edge, the set SHALL win.
REQ-024 user_irq SHALL equal IRQ_STATUS & IRQ_MASK, decoded directly from registers (no combinational path from bus inputs).
REQ-025 A read of IRQ_STATUS SHALL return the value before any same-cycle update.

Reset
REQ-026 While rst_n is low, wbs_ack_o=0, wbs_dat_o=0, IRQ_STATUS=0, IRQ_MASK=0, prev=0, every CTRL[i]=CTRL_RST, hence user_irq=0.
REQ-027 Reset asserted mid-transaction SHALL drop wbs_ack_o immediately; the pending write SHALL be discarded.
REQ-028 After rst_n rises, an irq_src already high SHALL produce one edge event on the first clock.

Verification
REQ-029 Read offset 0x00 at BASE_ADR -> ack one cycle later, wbs_dat_o=32'h5454_0001, then 0.
REQ-030 Write 32'hAABBCCDD to CTRL[1] with sel=4'b0101 after reset -> ctrl_o[63:32]=32'h00BB00DD; readback matches.
REQ-031 Mask=3'b010, pulse irq_src[1] -> IRQ_STATUS=3'b010, user_irq=3'b010; W1C 3'b010 -> user_irq=0.
REQ-032 W1C bit 0 on the same edge as an irq_src[0] rising edge -> IRQ_STATUS[0] stays 1.
REQ-033 Access at BASE_ADR+32'h100 -> no ack for 10 cycles, no register change; stb held on a hit -> ack pattern 0,1,0,1.
REQ-034 Assert rst_n low during a write ack cycle -> ack=0 immediately, CTRL unchanged at CTRL_RST.

Source files
------------

// File: rtl/tt_wb_ctrl.sv
// Wishbone classic slave with an ID word, a rising-edge interrupt controller
// (status/mask/force) and N_CTRL byte-writable 32-bit control registers.
// Each access is acknowledged one cycle after the request. Read data is
// registered and is driven only during the acknowledge cycle.
module tt_wb_ctrl #(
  parameter int unsigned N_CTRL   = 4,
  parameter int unsigned N_IRQ    = 3,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter logic [31:0] ID_VALUE = 32'h5454_0001,
  parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  input  logic [N_IRQ-1:0]      irq_src,
  output logic [32*N_CTRL-1:0]  ctrl_o,
  output logic [N_IRQ-1:0]      user_irq
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } bus_state_t;

  bus_state_t state_q, state_d;

  logic              ack;
  logic              hit;
  logic              wr_en;
  logic              rd_en;
  logic [31:0]       word_idx;
  logic [31:0]       lane32;
  logic [N_IRQ-1:0]  lane_irq;
  logic [N_IRQ-1:0]  dat_irq;
  logic [31:0]       rd_data;
  logic [31:0]       dat_q;

  logic [N_IRQ-1:0]  prev_q;
  logic [N_IRQ-1:0]  status_q;
  logic [N_IRQ-1:0]  mask_q;
  logic [N_IRQ-1:0]  set_vec;
  logic [N_IRQ-1:0]  clr_vec;
  logic [31:0]       ctrl_q [N_CTRL];

  logic              wr_status;
  logic              wr_mask;
  logic              wr_force;

  // Byte offset bits [1:0] carry no information for word-wide registers.
  logic              unused_adr;
  assign unused_adr = ^wbs_adr_i[1:0];

  assign ack       = (state_q == S_ACK);
  assign wbs_ack_o = ack;
  assign wbs_dat_o = dat_q;
  assign user_irq  = status_q & mask_q;

  // Request decode: a hit is only taken while no ack is outstanding, which
  // spaces acks of a held strobe to every second cycle.
  always_comb begin
    hit      = wbs_stb_i & wbs_cyc_i & ~ack &
               (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    wr_en    = hit & wbs_we_i;
    rd_en    = hit & ~wbs_we_i;
    word_idx = {26'b0, wbs_adr_i[7:2]};
    lane32   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    lane_irq = lane32[N_IRQ-1:0];
    dat_irq  = wbs_dat_i[N_IRQ-1:0];
    wr_status = wr_en && (word_idx == 32'd1);
    wr_mask   = wr_en && (word_idx == 32'd2);
    wr_force  = wr_en && (word_idx == 32'd3);
  end

  // Acknowledge state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: every hit produces exactly one ack cycle.
  always_comb begin
    state_d = S_IDLE;
    if (hit) state_d = S_ACK;
  end

  // Read mux over the current register values (pre-update on this edge).
  always_comb begin
    rd_data = '0;
    case (word_idx)
      32'd0:   rd_data = ID_VALUE;
      32'd1:   rd_data[N_IRQ-1:0] = status_q;
      32'd2:   rd_data[N_IRQ-1:0] = mask_q;
      default: begin
        for (int unsigned i = 0; i < N_CTRL; i++) begin
          if (word_idx == i + 32'd4) rd_data = ctrl_q[i];
        end
      end
    endcase
  end

  // Read data register: valid only in the ack cycle, zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     dat_q <= '0;
    else if (rd_en) dat_q <= rd_data;
    else            dat_q <= '0;
  end

  // Interrupt set/clear terms; OR-ing the set after the clear lets a set win.
  always_comb begin
    set_vec = irq_src & ~prev_q;
    clr_vec = '0;
    if (wr_force)  set_vec = set_vec | (dat_irq & lane_irq);
    if (wr_status) clr_vec = dat_irq & lane_irq;
  end

  // Interrupt edge history, status and mask registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      status_q <= '0;
      mask_q   <= '0;
    end else begin
      prev_q   <= irq_src;
      status_q <= (status_q & ~clr_vec) | set_vec;
      if (wr_mask) mask_q <= (mask_q & ~lane_irq) | (dat_irq & lane_irq);
    end
  end

  // Control registers with per-byte write enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CTRL; i++) ctrl_q[i] <= CTRL_RST;
    end else begin
      for (int unsigned i = 0; i < N_CTRL; i++) begin
        if (wr_en && (word_idx == i + 32'd4))
          ctrl_q[i] <= (ctrl_q[i] & ~lane32) | (wbs_dat_i & lane32);
      end
    end
  end

  // Flatten control registers onto the output bus.
  always_comb begin
    ctrl_o = '0;
    for (int unsigned i = 0; i < N_CTRL; i++) ctrl_o[32*i +: 32] = ctrl_q[i];
  end

endmodule

// File: tb/tb_tt_wb_ctrl.sv
// Directed bench for tt_wb_ctrl with default parameters.
module tb_tt_wb_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] ID   = 32'h5454_0001;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wbs_stb_i = 1'b0;
  logic         wbs_cyc_i = 1'b0;
  logic         wbs_we_i = 1'b0;
  logic [3:0]   wbs_sel_i = '0;
  logic [31:0]  wbs_adr_i = '0;
  logic [31:0]  wbs_dat_i = '0;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [2:0]   irq_src = '0;
  logic [127:0] ctrl_o;
  logic [2:0]   user_irq;

  int total = 0;
  int bad   = 0;

  tt_wb_ctrl #(
    .N_CTRL   (4),
    .N_IRQ    (3),
    .BASE_ADR (32'h3000_0000),
    .ID_VALUE (32'h5454_0001),
    .CTRL_RST (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .irq_src   (irq_src),
    .ctrl_o    (ctrl_o),
    .user_irq  (user_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic stb, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    wbs_stb_i = stb;
    wbs_cyc_i = stb;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
  endtask

  // One single-beat access; checks ack timing, read data and the idle data bus.
  task automatic bus_op(input string tag, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input logic [31:0] exp_rd);
    @(negedge clk);
    drive(1'b1, we, adr, dat, sel);
    #1 chk({tag, " pre-ack"}, wbs_ack_o, 1'b0);
    @(negedge clk);
    chk({tag, " ack"}, wbs_ack_o, 1'b1);
    chk({tag, " data"}, wbs_dat_o, we ? 32'd0 : exp_rd);
    drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk({tag, " ack drop"}, wbs_ack_o, 1'b0);
    chk({tag, " data idle"}, wbs_dat_o, 32'd0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst ack", wbs_ack_o, 1'b0);
    chk("rst dat", wbs_dat_o, 32'd0);
    chk("rst user_irq", user_irq, 3'b000);
    chk("rst ctrl", ctrl_o, 128'd0);
    rst_n = 1'b1;

    // ID read
    bus_op("id rd", 1'b0, BASE, 32'd0, 4'hF, ID);

    // Byte-lane write to CTRL[1]
    bus_op("ctrl1 wr", 1'b1, BASE + 32'h14, 32'hAABB_CCDD, 4'b0101, 32'd0);
    chk("ctrl1 value", ctrl_o[63:32], 32'h00BB_00DD);
    chk("ctrl0 untouched", ctrl_o[31:0], 32'd0);
    bus_op("ctrl1 rd", 1'b0, BASE + 32'h14, 32'd0, 4'hF, 32'h00BB_00DD);

    // Mask; upper bits beyond N_IRQ are dropped
    bus_op("mask wr", 1'b1, BASE + 32'h08, 32'hFFFF_FFFA, 4'hF, 32'd0);
    bus_op("mask rd", 1'b0, BASE + 32'h08, 32'd0, 4'hF, 32'd2);

    // Edge on irq_src[1]
    @(negedge clk); irq_src = 3'b010;
    @(negedge clk); irq_src = 3'b000;
    @(negedge clk);
    chk("irq1 user_irq", user_irq, 3'b010);
    bus_op("status rd a", 1'b0, BASE + 32'h04, 32'd0, 4'hF, 32'd2);
    bus_op("status w1c", 1'b1, BASE + 32'h04, 32'd2, 4'hF, 32'd0);
    chk("w1c user_irq", user_irq, 3'b000);
    bus_op("status rd b", 1'b0, BASE + 32'h04, 32'd0, 4'hF, 32'd0);

    // Force sets status, reads back 0; masked-off bit keeps user_irq low
    bus_op("force wr", 1'b1, BASE + 32'h0C, 32'd1, 4'hF, 32'd0);
    bus_op("force rd", 1'b0, BASE + 32'h0C, 32'd0, 4'hF, 32'd0);
    bus_op("status rd c", 1'b0, BASE + 32'h04, 32'd0, 4'hF, 32'd1);
    chk("masked user_irq", user_irq, 3'b000);

    // W1C of bit 0 on the same edge as an irq_src[0] rising edge
    @(negedge clk);
    drive(1'b1, 1'b1, BASE + 32'h04, 32'd1, 4'hF);
    irq_src = 3'b001;
    @(negedge clk);
    chk("race ack", wbs_ack_o, 1'b1);
    drive(1'b0, 1'b0, '0, '0, '0);
    bus_op("race status rd", 1'b0, BASE + 32'h04, 32'd0, 4'hF, 32'd1);
    irq_src = 3'b000;
    bus_op("w1c bit0", 1'b1, BASE + 32'h04, 32'd1, 4'hF, 32'd0);
    bus_op("status rd d", 1'b0, BASE + 32'h04, 32'd0, 4'hF, 32'd0);

    // Force with lane 0 disabled is ignored
    bus_op("force nolane", 1'b1, BASE + 32'h0C, 32'd7, 4'b1110, 32'd0);
    bus_op("status rd e", 1'b0, BASE + 32'h04, 32'd0, 4'hF, 32'd0);

    // Out-of-window access: never acked, no effect
    @(negedge clk);
    drive(1'b1, 1'b1, BASE + 32'h114, 32'hFFFF_FFFF, 4'hF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("miss no ack", wbs_ack_o, 1'b0);
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("miss ctrl1", ctrl_o[63:32], 32'h00BB_00DD);

    // Held strobe on a hit: ack 0,1,0,1
    @(negedge clk);
    drive(1'b1, 1'b0, BASE, 32'd0, 4'hF);
    #1 chk("held ack0", wbs_ack_o, 1'b0);
    @(negedge clk);
    chk("held ack1", wbs_ack_o, 1'b1);
    chk("held dat1", wbs_dat_o, ID);
    @(negedge clk);
    chk("held ack2", wbs_ack_o, 1'b0);
    chk("held dat2", wbs_dat_o, 32'd0);
    @(negedge clk);
    chk("held ack3", wbs_ack_o, 1'b1);
    chk("held dat3", wbs_dat_o, ID);
    drive(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("held end", wbs_ack_o, 1'b0);

    // Unmapped offset inside the window, and last CTRL index
    bus_op("unmapped rd", 1'b0, BASE + 32'h40, 32'd0, 4'hF, 32'd0);
    bus_op("unmapped wr", 1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, 32'd0);
    bus_op("ctrl3 wr", 1'b1, BASE + 32'h1C, 32'h1122_3344, 4'hF, 32'd0);
    chk("ctrl map", ctrl_o, {32'h1122_3344, 32'd0, 32'h00BB_00DD, 32'd0});

    // Reset during a write ack cycle; irq_src held high across release
    @(negedge clk);
    drive(1'b1, 1'b1, BASE + 32'h10, 32'h1234_5678, 4'hF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst ack", wbs_ack_o, 1'b0);
    chk("mid rst dat", wbs_dat_o, 32'd0);
    chk("mid rst ctrl", ctrl_o, 128'd0);
    chk("mid rst user_irq", user_irq, 3'b000);
    drive(1'b0, 1'b0, '0, '0, '0);
    irq_src = 3'b100;
    @(negedge clk);
    rst_n = 1'b1;
    bus_op("post rst status", 1'b0, BASE + 32'h04, 32'd0, 4'hF, 32'd4);
    bus_op("post rst w1c", 1'b1, BASE + 32'h04, 32'd4, 4'hF, 32'd0);
    bus_op("held src no edge", 1'b0, BASE + 32'h04, 32'd0, 4'hF, 32'd0);
    irq_src = 3'b000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
